game_sequencer: RTL and testbench

Parametrised phase sequencer for the symbol-counting game. It replaces the fixed prelim/game/answer/post chain and single-miss loss rule with one FSM. The FSM has configurable phase lengths, level count, multiple lives, a per-level tolerance and a running score. It sits between the 1 Hz tick source and the display/symbol-generator blocks, and it owns all phase, level and judging state.

---
 rtl/game_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: phase FSM for the symbol-counting game.
// Owns phase timing, level progression, lives, judging and score.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_PRE    | prelim countdown before the symbols run
// S_GAME   | symbol generator running
// S_ANSWER | generator stopped, user finalises the tally
// S_POST   | result shown, then next level / retry / end
// S_WIN    | all levels cleared, outputs held until start
// S_OVER   | lives exhausted, outputs held until start
module game_sequencer #(
    parameter int NUM_LEVELS = 8,
    parameter int MAX_LIVES  = 3,
    parameter int PRE_SECS   = 3,
    parameter int GAME_SECS  = 10,
    parameter int ANS_SECS   = 5,
    parameter int POST_SECS  = 3,
    parameter int CNT_W      = 8,
    parameter int TOL_BASE   = 2,
    parameter int SYM_BASE   = 100000000,
    parameter int SYM_STEP   = 10000000,
    parameter int SYM_MIN    = 20000000
) (
    input  logic             Clk100M,
    input  logic             reset,
    input  logic             tick1Hz,
    input  logic             start,
    input  logic [CNT_W-1:0] userCount,
    input  logic [CNT_W-1:0] magicCount,
    output logic [2:0]       phase,
    output logic [3:0]       curLevel,
    output logic [2:0]       lives,
    output logic [7:0]       secsLeft,
    output logic [31:0]      symGenMax,
    output logic             startGen,
    output logic             stopGen,
    output logic             stopCount,
    output logic [CNT_W-1:0] difference,
    output logic             levelPass,
    output logic             levelFail,
    output logic [15:0]      score
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_GAME   = 3'd2,
        S_ANSWER = 3'd3,
        S_POST   = 3'd4,
        S_WIN    = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    // A zero-length phase would never reach its terminal count, so run it for one tick.
    localparam logic [7:0] PRE_LOAD  = (PRE_SECS  == 0) ? 8'd1 : 8'(PRE_SECS);
    localparam logic [7:0] GAME_LOAD = (GAME_SECS == 0) ? 8'd1 : 8'(GAME_SECS);
    localparam logic [7:0] ANS_LOAD  = (ANS_SECS  == 0) ? 8'd1 : 8'(ANS_SECS);
    localparam logic [7:0] POST_LOAD = (POST_SECS == 0) ? 8'd1 : 8'(POST_SECS);
    localparam logic [2:0] LIVES_INIT = 3'(MAX_LIVES);
    localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);

    state_t           state_q, state_n;
    logic [3:0]       level_q, level_n;
    logic [2:0]       lives_q, lives_n;
    logic [7:0]       secs_q, secs_n;
    logic [15:0]      score_q, score_n;
    logic [CNT_W-1:0] diff_q, diff_n;
    logic             result_q, result_n;
    logic             start_gen_q, start_gen_n;
    logic             stop_gen_q, stop_gen_n;
    logic             stop_count_q, stop_count_n;
    logic             pass_q, pass_n;
    logic             fail_q, fail_n;
    logic [31:0]      sym_q, sym_calc;

    logic [CNT_W-1:0] abs_diff;
    logic [31:0]      tol;
    logic             judge_pass;
    logic [16:0]      score_sum;
    logic             last_tick;
    logic [63:0]      sym_drop;

    // Judging arithmetic: unsigned |user - magic|, level tolerance, saturating score.
    always_comb begin
        abs_diff   = (userCount >= magicCount) ? (userCount - magicCount) : (magicCount - userCount);
        tol        = (TOL_BASE > int'(level_q)) ? 32'(TOL_BASE - int'(level_q)) : 32'd0;
        judge_pass = (32'(abs_diff) <= tol);
        score_sum  = {1'b0, score_q} + {13'd0, level_q} + 17'd1;
        last_tick  = tick1Hz && (secs_q <= 8'd1);
    end

    // Next-state and registered-output logic for the phase FSM.
    always_comb begin
        state_n      = state_q;
        level_n      = level_q;
        lives_n      = lives_q;
        secs_n       = secs_q;
        score_n      = score_q;
        diff_n       = diff_q;
        result_n     = result_q;
        start_gen_n  = 1'b0;
        stop_gen_n   = 1'b0;
        stop_count_n = 1'b0;
        pass_n       = 1'b0;
        fail_n       = 1'b0;
        case (state_q)
            S_IDLE, S_WIN, S_OVER: begin
                if (start) begin
                    state_n = S_PRE;
                    level_n = 4'd0;
                    lives_n = LIVES_INIT;
                    score_n = 16'd0;
                    secs_n  = PRE_LOAD;
                end
            end
            S_PRE: begin
                if (last_tick) begin
                    state_n     = S_GAME;
                    secs_n      = GAME_LOAD;
                    start_gen_n = 1'b1;
                end else if (tick1Hz) begin
                    secs_n = secs_q - 8'd1;
                end
            end
            S_GAME: begin
                if (last_tick) begin
                    state_n    = S_ANSWER;
                    secs_n     = ANS_LOAD;
                    stop_gen_n = 1'b1;
                end else if (tick1Hz) begin
                    secs_n = secs_q - 8'd1;
                end
            end
            S_ANSWER: begin
                if (last_tick) begin
                    state_n      = S_POST;
                    secs_n       = POST_LOAD;
                    stop_count_n = 1'b1;
                    diff_n       = abs_diff;
                    result_n     = judge_pass;
                    if (judge_pass) begin
                        pass_n  = 1'b1;
                        score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    end else begin
                        fail_n  = 1'b1;
                        lives_n = lives_q - 3'd1;
                    end
                end else if (tick1Hz) begin
                    secs_n = secs_q - 8'd1;
                end
            end
            S_POST: begin
                if (last_tick) begin
                    secs_n = 8'd0;
                    if (result_q) begin
                        if (level_q == LAST_LEVEL) begin
                            state_n = S_WIN;
                        end else begin
                            state_n = S_PRE;
                            level_n = level_q + 4'd1;
                            secs_n  = PRE_LOAD;
                        end
                    end else if (lives_q == 3'd0) begin
                        state_n = S_OVER;
                    end else begin
                        state_n = S_PRE;
                        secs_n  = PRE_LOAD;
                    end
                end else if (tick1Hz) begin
                    secs_n = secs_q - 8'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                secs_n  = 8'd0;
            end
        endcase
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge Clk100M) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            level_q      <= 4'd0;
            lives_q      <= LIVES_INIT;
            secs_q       <= 8'd0;
            score_q      <= 16'd0;
            diff_q       <= '0;
            result_q     <= 1'b0;
            start_gen_q  <= 1'b0;
            stop_gen_q   <= 1'b0;
            stop_count_q <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            level_q      <= level_n;
            lives_q      <= lives_n;
            secs_q       <= secs_n;
            score_q      <= score_n;
            diff_q       <= diff_n;
            result_q     <= result_n;
            start_gen_q  <= start_gen_n;
            stop_gen_q   <= stop_gen_n;
            stop_count_q <= stop_count_n;
            pass_q       <= pass_n;
            fail_q       <= fail_n;
        end
    end

    // Generator period for the current level, clamped at the floor without underflow.
    always_comb begin
        sym_drop = 64'(level_q) * 64'(SYM_STEP);
        if (sym_drop + 64'(SYM_MIN) > 64'(SYM_BASE)) begin
            sym_calc = 32'(SYM_MIN);
        end else begin
            sym_calc = 32'(64'(SYM_BASE) - sym_drop);
        end
    end

    // Registered generator period, one cycle behind curLevel.
    always_ff @(posedge Clk100M) begin
        if (!reset) begin
            sym_q <= 32'(SYM_BASE);
        end else begin
            sym_q <= sym_calc;
        end
    end

    assign phase      = state_q;
    assign curLevel   = level_q;
    assign lives      = lives_q;
    assign secsLeft   = secs_q;
    assign symGenMax  = sym_q;
    assign startGen   = start_gen_q;
    assign stopGen    = stop_gen_q;
    assign stopCount  = stop_count_q;
    assign difference = diff_q;
    assign levelPass  = pass_q;
    assign levelFail  = fail_q;
    assign score      = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: judge results go through per-instance scoreboards,
// phase/level state is checked directly by the stimulus thread.
module tb_game_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance a: default parameters.
    logic       tick_a, start_a;
    logic [7:0] user_a, magic_a;
    logic [2:0] phase_a, lives_a;
    logic [3:0] level_a;
    logic [7:0] secs_a, diff_a;
    logic [31:0] sym_a;
    logic       sg_a, sp_a, sc_a, pass_a, fail_a;
    logic [15:0] score_a;

    // Instances b (2 levels) and c (10 levels) share stimulus, all phases one tick.
    logic       tick_b, start_b;
    logic [7:0] user_b, magic_b;
    logic [2:0] phase_b, lives_b, phase_c, lives_c;
    logic [3:0] level_b, level_c;
    logic [7:0] secs_b, diff_b, secs_c, diff_c;
    logic [31:0] sym_b, sym_c;
    logic       sg_b, sp_b, sc_b, pass_b, fail_b;
    logic       sg_c, sp_c, sc_c, pass_c, fail_c;
    logic [15:0] score_b, score_c;

    game_sequencer dut_a (
        .Clk100M(clk), .reset(reset_n), .tick1Hz(tick_a), .start(start_a),
        .userCount(user_a), .magicCount(magic_a),
        .phase(phase_a), .curLevel(level_a), .lives(lives_a), .secsLeft(secs_a),
        .symGenMax(sym_a), .startGen(sg_a), .stopGen(sp_a), .stopCount(sc_a),
        .difference(diff_a), .levelPass(pass_a), .levelFail(fail_a), .score(score_a)
    );

    game_sequencer #(.NUM_LEVELS(2), .PRE_SECS(0), .GAME_SECS(0), .ANS_SECS(0), .POST_SECS(0)) dut_b (
        .Clk100M(clk), .reset(reset_n), .tick1Hz(tick_b), .start(start_b),
        .userCount(user_b), .magicCount(magic_b),
        .phase(phase_b), .curLevel(level_b), .lives(lives_b), .secsLeft(secs_b),
        .symGenMax(sym_b), .startGen(sg_b), .stopGen(sp_b), .stopCount(sc_b),
        .difference(diff_b), .levelPass(pass_b), .levelFail(fail_b), .score(score_b)
    );

    game_sequencer #(.NUM_LEVELS(10), .PRE_SECS(0), .GAME_SECS(0), .ANS_SECS(0), .POST_SECS(0)) dut_c (
        .Clk100M(clk), .reset(reset_n), .tick1Hz(tick_b), .start(start_b),
        .userCount(user_b), .magicCount(magic_b),
        .phase(phase_c), .curLevel(level_c), .lives(lives_c), .secsLeft(secs_c),
        .symGenMax(sym_c), .startGen(sg_c), .stopGen(sp_c), .stopCount(sc_c),
        .difference(diff_c), .levelPass(pass_c), .levelFail(fail_c), .score(score_c)
    );

    typedef struct {
        bit pass;
        int diff;
        int score;
        int lives;
        int level;
    } judge_t;

    judge_t q_a[$];
    judge_t q_b[$];
    judge_t q_c[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_sg = 0;
    int cnt_sp = 0;
    int cnt_sc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic judge_t mk(bit p, int d, int s, int l, int lv);
        judge_t e;
        e.pass  = p;
        e.diff  = d;
        e.score = s;
        e.lives = l;
        e.level = lv;
        return e;
    endfunction

    task automatic cmp_judge(input string tag, input judge_t e, input logic p, input logic f,
                             input int d, input int s, input int l, input int lv);
        check({tag, ".levelPass"}, longint'(p), longint'(e.pass));
        check({tag, ".levelFail"}, longint'(f), longint'(!e.pass));
        check({tag, ".difference"}, d, e.diff);
        check({tag, ".score"}, s, e.score);
        check({tag, ".lives"}, l, e.lives);
        check({tag, ".curLevel"}, lv, e.level);
    endtask

    task automatic unexpected(input string tag, input logic p, input logic f);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: judge pulse pass=%0d fail=%0d, required no pulse", tag, p, f);
    endtask

    // Scoreboard monitors: pop one expected judge result per DUT judge pulse.
    always @(negedge clk) begin
        judge_t e;
        if (pass_a || fail_a) begin
            if (q_a.size() == 0) unexpected("judge_a", pass_a, fail_a);
            else begin
                e = q_a.pop_front();
                cmp_judge("judge_a", e, pass_a, fail_a, int'(diff_a), int'(score_a), int'(lives_a), int'(level_a));
            end
        end
    end

    always @(negedge clk) begin
        judge_t e;
        if (pass_b || fail_b) begin
            if (q_b.size() == 0) unexpected("judge_b", pass_b, fail_b);
            else begin
                e = q_b.pop_front();
                cmp_judge("judge_b", e, pass_b, fail_b, int'(diff_b), int'(score_b), int'(lives_b), int'(level_b));
            end
        end
    end

    always @(negedge clk) begin
        judge_t e;
        if (pass_c || fail_c) begin
            if (q_c.size() == 0) unexpected("judge_c", pass_c, fail_c);
            else begin
                e = q_c.pop_front();
                cmp_judge("judge_c", e, pass_c, fail_c, int'(diff_c), int'(score_c), int'(lives_c), int'(level_c));
            end
        end
    end

    // Pulse counters for instance a.
    always @(negedge clk) begin
        if (sg_a) cnt_sg++;
        if (sp_a) cnt_sp++;
        if (sc_a) cnt_sc++;
    end

    task automatic ticks_a(input int n);
        repeat (n) begin
            tick_a = 1'b1;
            @(posedge clk); #1;
            tick_a = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic ticks_b(input int n);
        repeat (n) begin
            tick_b = 1'b1;
            @(posedge clk); #1;
            tick_b = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic start_pulse_a(input bit with_tick);
        start_a = 1'b1;
        tick_a  = with_tick;
        @(posedge clk); #1;
        start_a = 1'b0;
        tick_a  = 1'b0;
    endtask

    task automatic play_a(input int u, input int m, input judge_t e);
        user_a  = 8'(u);
        magic_a = 8'(m);
        q_a.push_back(e);
        ticks_a(21);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".phase"}, phase_a, 0);
        check({tag, ".curLevel"}, level_a, 0);
        check({tag, ".lives"}, lives_a, 3);
        check({tag, ".secsLeft"}, secs_a, 0);
        check({tag, ".score"}, score_a, 0);
        check({tag, ".difference"}, diff_a, 0);
        check({tag, ".symGenMax"}, sym_a, 100000000);
        check({tag, ".pulses"}, {sg_a, sp_a, sc_a, pass_a, fail_a}, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        tick_a = 1'b0; start_a = 1'b0; user_a = 8'd0; magic_a = 8'd0;
        tick_b = 1'b0; start_b = 1'b0; user_b = 8'd0; magic_b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Start and tick together: start wins, PRE loaded with full length.
        start_pulse_a(1'b1);
        check("start_tick.phase", phase_a, 1);
        check("start_tick.secs", secs_a, 3);
        ticks_a(3);
        check("game_entry.phase", phase_a, 2);
        check("game_entry.secs", secs_a, 10);
        ticks_a(2);
        start_pulse_a(1'b0);
        check("start_in_game.phase", phase_a, 2);
        check("start_in_game.secs", secs_a, 8);
        user_a = 8'd12; magic_a = 8'd12;
        q_a.push_back(mk(1'b1, 0, 1, 3, 0));
        ticks_a(8);
        check("answer_entry.phase", phase_a, 3);
        check("answer_entry.secs", secs_a, 5);
        ticks_a(5);
        check("post_entry.phase", phase_a, 4);
        check("post_entry.secs", secs_a, 3);
        ticks_a(3);
        check("lvl1.phase", phase_a, 1);
        check("lvl1.curLevel", level_a, 1);
        check("lvl1.secs", secs_a, 3);
        check("lvl1.symGenMax", sym_a, 90000000);
        check("startGen_count", cnt_sg, 1);
        check("stopGen_count", cnt_sp, 1);
        check("stopCount_count", cnt_sc, 1);

        // Climb to level 3 (tolerance 1 then 0), then reset mid-GAME.
        play_a(10, 11, mk(1'b1, 1, 3, 3, 1));
        play_a(7, 7, mk(1'b1, 0, 6, 3, 2));
        check("lvl3.curLevel", level_a, 3);
        check("lvl3.score", score_a, 6);
        check("lvl3.symGenMax", sym_a, 70000000);
        ticks_a(7);
        check("lvl3_game.phase", phase_a, 2);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_reset_state("mid_reset");
        reset_n = 1'b1;

        // Level 0 miss: difference 3 exceeds tolerance 2.
        start_pulse_a(1'b0);
        play_a(5, 8, mk(1'b0, 3, 0, 2, 0));
        check("miss0.phase", phase_a, 1);
        check("miss0.curLevel", level_a, 0);
        check("miss0.lives", lives_a, 2);
        check("miss0.difference", diff_a, 3);

        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reach level 2 then miss three times, including large no-wrap differences.
        start_pulse_a(1'b0);
        play_a(12, 12, mk(1'b1, 0, 1, 3, 0));
        play_a(9, 8, mk(1'b1, 1, 3, 3, 1));
        play_a(200, 3, mk(1'b0, 197, 3, 2, 2));
        play_a(3, 200, mk(1'b0, 197, 3, 1, 2));
        play_a(0, 255, mk(1'b0, 255, 3, 0, 2));
        check("over.phase", phase_a, 6);
        check("over.lives", lives_a, 0);
        check("over.secs", secs_a, 0);
        check("over.difference", diff_a, 255);
        ticks_a(3);
        check("over_ticks.phase", phase_a, 6);
        check("over_ticks.curLevel", level_a, 2);
        start_pulse_a(1'b0);
        check("restart.phase", phase_a, 1);
        check("restart.lives", lives_a, 3);
        check("restart.curLevel", level_a, 0);
        check("restart.score", score_a, 0);
        check("restart.secs", secs_a, 3);
        check("queue_a_drained", q_a.size(), 0);

        // Instances b/c: one-tick phases, every level passes with equal counts.
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        check("zero_secs.phase_c", phase_c, 1);
        check("zero_secs.secs_c", secs_c, 1);
        q_b.push_back(mk(1'b1, 0, 1, 3, 0));
        q_b.push_back(mk(1'b1, 0, 3, 3, 1));
        for (int lv = 0; lv < 9; lv++) begin
            q_c.push_back(mk(1'b1, 0, (lv + 1) * (lv + 2) / 2, 3, lv));
        end
        ticks_b(8);
        check("win.phase_b", phase_b, 5);
        check("win.score_b", score_b, 3);
        check("win.curLevel_b", level_b, 1);
        ticks_b(28);
        check("win_hold.phase_b", phase_b, 5);
        check("win_hold.score_b", score_b, 3);
        check("win_hold.curLevel_b", level_b, 1);
        check("win_hold.secs_b", secs_b, 0);
        check("lvl9.phase_c", phase_c, 1);
        check("lvl9.curLevel_c", level_c, 9);
        check("lvl9.score_c", score_c, 45);
        check("lvl9.symGenMax_c", sym_c, 20000000);
        check("queue_b_drained", q_b.size(), 0);
        check("queue_c_drained", q_c.size(), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
